// File: rtl/axis_gen_ctrl.sv
// -----------------------------------------------------------------------------
// axis_gen_ctrl
//
// Run controller for axis_data_gen. Captures a traffic profile (packet length,
// period, packet count) when a run is started. It then sequences the generator
// enable and stops the generator on a packet boundary. It also snoops the
// generator's AXIS TX handshake to report packets, beats and backpressure
// stalls for the current or most recent run.
//
// Ports
//   axis_streaming_data_clk  streaming clock
//   axis_streaming_rst_n     synchronous reset, active low
//   cfg_start                1-cycle pulse, begin a run
//   cfg_stop                 1-cycle pulse, end a run at the next packet boundary
//   cfg_pkt_length           packet length in bytes, captured on an accepted start
//   cfg_period               cycles between packet starts, captured on an accepted start
//   cfg_pkt_count            packets per run, 0 means run until cfg_stop
//   gen_enable               enable to the generator
//   gen_pkt_length           packet length to the generator, constant while busy
//   gen_period               period to the generator, constant while busy
//   mon_tvalid/tready/tlast  snoop of the generator TX handshake
//   status_busy              high in LOAD, RUN and DRAIN
//   status_done              1-cycle pulse when a run completes
//   status_err               sticky, the last start request was rejected
//   status_pkt_sent          tlast handshakes in the current/last run
//   status_beat_sent         tvalid&tready beats in the current/last run
//   status_stall_cycles      cycles with tvalid&!tready in the current/last run
// -----------------------------------------------------------------------------
module axis_gen_ctrl #(
    parameter int unsigned G_LEN_WIDTH = 16,
    parameter int unsigned G_CNT_WIDTH = 32
) (
    input  logic                   axis_streaming_data_clk,
    input  logic                   axis_streaming_rst_n,
    input  logic                   cfg_start,
    input  logic                   cfg_stop,
    input  logic [G_LEN_WIDTH-1:0] cfg_pkt_length,
    input  logic [G_LEN_WIDTH-1:0] cfg_period,
    input  logic [G_CNT_WIDTH-1:0] cfg_pkt_count,
    output logic                   gen_enable,
    output logic [G_LEN_WIDTH-1:0] gen_pkt_length,
    output logic [G_LEN_WIDTH-1:0] gen_period,
    input  logic                   mon_tvalid,
    input  logic                   mon_tready,
    input  logic                   mon_tlast,
    output logic                   status_busy,
    output logic                   status_done,
    output logic                   status_err,
    output logic [G_CNT_WIDTH-1:0] status_pkt_sent,
    output logic [G_CNT_WIDTH-1:0] status_beat_sent,
    output logic [G_CNT_WIDTH-1:0] status_stall_cycles
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [G_CNT_WIDTH-1:0] CNT_MAX = {G_CNT_WIDTH{1'b1}};
    localparam logic [G_CNT_WIDTH-1:0] CNT_ONE = {{(G_CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                 state;
    state_t                 state_next;
    logic [G_CNT_WIDTH-1:0] target;
    logic                   in_pkt;
    logic                   beat;
    logic                   pkt_end;
    logic                   stall;
    logic                   start_req;
    logic                   cfg_ok;
    logic                   start_accept;
    logic                   counting;
    logic [G_CNT_WIDTH-1:0] pkt_sent_inc;
    logic [G_CNT_WIDTH-1:0] beat_sent_inc;
    logic [G_CNT_WIDTH-1:0] stall_inc;

    // Handshake decode and increment values for the status counters. A start
    // that arrives together with a stop is treated as no request at all. Each
    // counter sticks at all-ones rather than wrapping back to zero.
    always_comb begin
        beat          = mon_tvalid & mon_tready;
        pkt_end       = beat & mon_tlast;
        stall         = mon_tvalid & ~mon_tready;
        start_req     = cfg_start & ~cfg_stop;
        cfg_ok        = (cfg_pkt_length != '0) && (cfg_period != '0);
        start_accept  = (state == ST_IDLE) && start_req && cfg_ok;
        counting      = (state == ST_RUN) || (state == ST_DRAIN);
        pkt_sent_inc  = (status_pkt_sent == CNT_MAX) ? CNT_MAX : status_pkt_sent + CNT_ONE;
        beat_sent_inc = (status_beat_sent == CNT_MAX) ? CNT_MAX : status_beat_sent + CNT_ONE;
        stall_inc     = (status_stall_cycles == CNT_MAX) ? CNT_MAX : status_stall_cycles + CNT_ONE;
    end

    // State register for the run sequencer.
    always_ff @(posedge axis_streaming_data_clk) begin
        if (!axis_streaming_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and state-decoded outputs. LOAD holds the enable low
    // for one cycle so the generator sees a stable profile before it starts.
    // A target of zero means the run only ends on cfg_stop. DRAIN waits until
    // the packet in flight has closed and the generator has gone quiet.
    always_comb begin
        state_next  = state;
        gen_enable  = 1'b0;
        status_busy = 1'b0;
        status_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_accept) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                status_busy = 1'b1;
                state_next  = cfg_stop ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                status_busy = 1'b1;
                gen_enable  = 1'b1;
                if (cfg_stop || (pkt_end && (target != '0) && (pkt_sent_inc == target))) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                status_busy = 1'b1;
                if (!in_pkt && !mon_tvalid) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                status_done = 1'b1;
                state_next  = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Profile capture and the sticky error flag. A rejected start only sets
    // the error flag. The profile from the previous run stays untouched.
    always_ff @(posedge axis_streaming_data_clk) begin
        if (!axis_streaming_rst_n) begin
            gen_pkt_length <= '0;
            gen_period     <= '0;
            target         <= '0;
            status_err     <= 1'b0;
        end else if ((state == ST_IDLE) && start_req) begin
            if (cfg_ok) begin
                gen_pkt_length <= cfg_pkt_length;
                gen_period     <= cfg_period;
                target         <= cfg_pkt_count;
                status_err     <= 1'b0;
            end else begin
                status_err <= 1'b1;
            end
        end
    end

    // Status counters. They are cleared on an accepted start. They advance
    // only in RUN and DRAIN, so packets that finish during the drain are
    // still counted. They keep their values in IDLE after a run ends.
    always_ff @(posedge axis_streaming_data_clk) begin
        if (!axis_streaming_rst_n) begin
            status_pkt_sent     <= '0;
            status_beat_sent    <= '0;
            status_stall_cycles <= '0;
        end else if (start_accept) begin
            status_pkt_sent     <= '0;
            status_beat_sent    <= '0;
            status_stall_cycles <= '0;
        end else if (counting) begin
            if (pkt_end) begin
                status_pkt_sent <= pkt_sent_inc;
            end
            if (beat) begin
                status_beat_sent <= beat_sent_inc;
            end
            if (stall) begin
                status_stall_cycles <= stall_inc;
            end
        end
    end

    // Tracks whether the generator is partway through a packet. This stops
    // DRAIN from ending between beats while tvalid is briefly low.
    always_ff @(posedge axis_streaming_data_clk) begin
        if (!axis_streaming_rst_n) begin
            in_pkt <= 1'b0;
        end else if (pkt_end) begin
            in_pkt <= 1'b0;
        end else if (beat) begin
            in_pkt <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axis_gen_ctrl.sv
// -----------------------------------------------------------------------------
// tb_axis_gen_ctrl
//
// Bench for axis_gen_ctrl. A simple traffic generator drives the snooped AXIS
// handshake from the controller's gen_* outputs. One beat carries 128 bytes,
// and a new packet starts every gen_period cycles while enabled.
//
// A behavioural model tracks the run phase and the counters directly from the
// wires. It is compared with every DUT output on every falling edge. The
// directed tests add literal expectations that were worked out by hand.
// -----------------------------------------------------------------------------
module tb_axis_gen_ctrl;

    localparam int MD_IDLE  = 0;
    localparam int MD_LOAD  = 1;
    localparam int MD_RUN   = 2;
    localparam int MD_DRAIN = 3;
    localparam int MD_DONE  = 4;
    localparam longint SAT  = 64'h0000_0000_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_start = 1'b0;
    logic        cfg_stop = 1'b0;
    logic [15:0] cfg_pkt_length = '0;
    logic [15:0] cfg_period = '0;
    logic [31:0] cfg_pkt_count = '0;
    logic        gen_enable;
    logic [15:0] gen_pkt_length;
    logic [15:0] gen_period;
    logic        mon_tvalid = 1'b0;
    logic        mon_tready = 1'b1;
    logic        mon_tlast = 1'b0;
    logic        status_busy;
    logic        status_done;
    logic        status_err;
    logic [31:0] status_pkt_sent;
    logic [31:0] status_beat_sent;
    logic [31:0] status_stall_cycles;

    int checks = 0;
    int errors = 0;
    int dut_done_cnt = 0;
    bit chk_en = 1'b0;

    int     m_mode = MD_IDLE;
    logic   [15:0] m_len = '0;
    logic   [15:0] m_per = '0;
    longint m_tgt = 0;
    longint m_pkt = 0;
    longint m_beat = 0;
    longint m_stall = 0;
    bit     m_err = 1'b0;
    bit     m_inpkt = 1'b0;

    bit g_active = 1'b0;
    int g_left = 0;
    int g_per = 0;
    int g_started = 0;
    int g_beats = 0;

    axis_gen_ctrl #(
        .G_LEN_WIDTH(16),
        .G_CNT_WIDTH(32)
    ) dut (
        .axis_streaming_data_clk(clk),
        .axis_streaming_rst_n   (rst_n),
        .cfg_start              (cfg_start),
        .cfg_stop               (cfg_stop),
        .cfg_pkt_length         (cfg_pkt_length),
        .cfg_period             (cfg_period),
        .cfg_pkt_count          (cfg_pkt_count),
        .gen_enable             (gen_enable),
        .gen_pkt_length         (gen_pkt_length),
        .gen_period             (gen_period),
        .mon_tvalid             (mon_tvalid),
        .mon_tready             (mon_tready),
        .mon_tlast              (mon_tlast),
        .status_busy            (status_busy),
        .status_done            (status_done),
        .status_err             (status_err),
        .status_pkt_sent        (status_pkt_sent),
        .status_beat_sent       (status_beat_sent),
        .status_stall_cycles    (status_stall_cycles)
    );

    always #5 clk = ~clk;

    // Counters only ever step by one, so clamping the sum at all-ones
    // reproduces the required saturating behaviour.
    function automatic longint sat(input longint v);
        return (v > SAT) ? SAT : v;
    endfunction

    // Reference model. It follows the run phases described for the block and
    // counts what it sees on the handshake wires.
    always @(posedge clk) begin
        bit hs;
        bit pend;
        bit stl;
        hs   = mon_tvalid && mon_tready;
        pend = hs && mon_tlast;
        stl  = mon_tvalid && !mon_tready;
        if (!rst_n) begin
            m_mode  <= MD_IDLE;
            m_len   <= '0;
            m_per   <= '0;
            m_tgt   <= 0;
            m_pkt   <= 0;
            m_beat  <= 0;
            m_stall <= 0;
            m_err   <= 1'b0;
            m_inpkt <= 1'b0;
        end else begin
            m_inpkt <= pend ? 1'b0 : (hs ? 1'b1 : m_inpkt);
            if (m_mode == MD_RUN || m_mode == MD_DRAIN) begin
                m_pkt   <= sat(m_pkt + longint'(pend));
                m_beat  <= sat(m_beat + longint'(hs));
                m_stall <= sat(m_stall + longint'(stl));
            end
            if (m_mode == MD_IDLE) begin
                if (cfg_start && !cfg_stop) begin
                    if (cfg_pkt_length != 0 && cfg_period != 0) begin
                        m_mode  <= MD_LOAD;
                        m_len   <= cfg_pkt_length;
                        m_per   <= cfg_period;
                        m_tgt   <= longint'(cfg_pkt_count);
                        m_pkt   <= 0;
                        m_beat  <= 0;
                        m_stall <= 0;
                        m_err   <= 1'b0;
                    end else begin
                        m_err <= 1'b1;
                    end
                end
            end else if (m_mode == MD_LOAD) begin
                m_mode <= cfg_stop ? MD_DONE : MD_RUN;
            end else if (m_mode == MD_RUN) begin
                if (cfg_stop || (pend && m_tgt != 0 && sat(m_pkt + 1) >= m_tgt)) begin
                    m_mode <= MD_DRAIN;
                end
            end else if (m_mode == MD_DRAIN) begin
                if (!m_inpkt && !mon_tvalid) begin
                    m_mode <= MD_DONE;
                end
            end else begin
                m_mode <= MD_IDLE;
            end
        end
    end

    // Continuous comparison of all DUT outputs against the model. It also
    // counts the done pulses so the tests can check their number.
    always @(negedge clk) begin
        logic [131:0] exp_vec;
        logic [131:0] act_vec;
        if (chk_en) begin
            exp_vec = {m_mode == MD_RUN,
                       (m_mode == MD_LOAD) || (m_mode == MD_RUN) || (m_mode == MD_DRAIN),
                       m_mode == MD_DONE, m_err, m_len, m_per,
                       32'(m_pkt), 32'(m_beat), 32'(m_stall)};
            act_vec = {gen_enable, status_busy, status_done, status_err, gen_pkt_length,
                       gen_period, status_pkt_sent, status_beat_sent, status_stall_cycles};
            checks++;
            if (act_vec !== exp_vec) begin
                errors++;
                $display("[TB] FAIL model_compare t=%0t got=%h expected=%h", $time, act_vec, exp_vec);
            end
            if (status_done === 1'b1) begin
                dut_done_cnt++;
            end
        end
    end

    // Literal comparison used by the directed tests.
    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s got=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Advances one clock and then steps the traffic generator. The generator
    // uses the enable and handshake values from the cycle that just ended.
    task automatic tick();
        bit en;
        bit hs;
        bit rst_now;
        en      = gen_enable;
        hs      = mon_tvalid && mon_tready;
        rst_now = !rst_n;
        @(posedge clk);
        #1;
        if (rst_now) begin
            g_active = 1'b0;
            g_left   = 0;
            g_per    = 0;
        end else begin
            if (hs && g_active) begin
                g_left--;
                g_beats++;
                if (g_left <= 0) begin
                    g_active = 1'b0;
                end
            end
            if (en) begin
                if (g_per == 0) begin
                    if (!g_active) begin
                        g_active = 1'b1;
                        g_left   = (int'(gen_pkt_length) + 127) / 128;
                        if (g_left < 1) begin
                            g_left = 1;
                        end
                        g_started++;
                        g_per = int'(gen_period) - 1;
                    end
                end else begin
                    g_per--;
                end
            end else begin
                g_per = 0;
            end
        end
        mon_tvalid = g_active;
        mon_tlast  = g_active && (g_left == 1);
    endtask

    // Drives one cycle of control inputs. The start and stop pulses last for
    // exactly that one cycle.
    task automatic applyStimulus(input bit start, input bit stop, input int len,
                                 input int per, input longint cnt);
        cfg_start      = start;
        cfg_stop       = stop;
        cfg_pkt_length = 16'(len);
        cfg_period     = 16'(per);
        cfg_pkt_count  = 32'(cnt);
        tick();
        cfg_start = 1'b0;
        cfg_stop  = 1'b0;
    endtask

    // Waits for the done pulse within a cycle budget. Running out of budget
    // counts as a failed check.
    task automatic waitDone(input string name, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (status_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput(name, longint'(seen), 1);
    endtask

    task automatic waitValid(input string name, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (mon_tvalid) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput(name, longint'(seen), 1);
    endtask

    initial begin
        int done_base;
        int start_base;
        bit hit;

        // Reset held for five cycles, then released.
        tick();
        chk_en = 1'b1;
        repeat (4) tick();
        checkOutput("rst_enable", gen_enable, 0);
        checkOutput("rst_busy", status_busy, 0);
        checkOutput("rst_err", status_err, 0);
        checkOutput("rst_pkt", status_pkt_sent, 0);
        rst_n = 1'b1;
        tick();
        checkOutput("rel_enable", gen_enable, 0);
        checkOutput("rel_busy", status_busy, 0);

        // Run of three 512-byte packets.
        done_base  = dut_done_cnt;
        start_base = g_started;
        applyStimulus(1, 0, 512, 128, 3);
        checkOutput("t2_load_enable", gen_enable, 0);
        checkOutput("t2_load_busy", status_busy, 1);
        tick();
        checkOutput("t2_run_enable", gen_enable, 1);
        checkOutput("t2_gen_len", gen_pkt_length, 512);
        checkOutput("t2_gen_period", gen_period, 128);
        waitDone("t2_done_seen", 1000);
        tick();
        checkOutput("t2_pkt_sent", status_pkt_sent, 3);
        checkOutput("t2_beat_sent", status_beat_sent, 12);
        checkOutput("t2_done_pulses", dut_done_cnt - done_base, 1);
        checkOutput("t2_busy_low", status_busy, 0);
        repeat (200) tick();
        checkOutput("t2_enable_stays_low", gen_enable, 0);
        checkOutput("t2_no_extra_pkt", g_started - start_base, 3);

        // Continuous run stopped partway through the third packet.
        done_base  = dut_done_cnt;
        start_base = g_started;
        applyStimulus(1, 0, 512, 128, 0);
        hit = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if ((g_started - start_base) == 3 && g_active && g_left == 2) begin
                hit = 1'b1;
                break;
            end
        end
        checkOutput("t3_reach_pkt3", longint'(hit), 1);
        applyStimulus(0, 1, 512, 128, 0);
        checkOutput("t3_drain_enable", gen_enable, 0);
        checkOutput("t3_drain_busy", status_busy, 1);
        waitDone("t3_done_seen", 50);
        tick();
        checkOutput("t3_pkt_sent", status_pkt_sent, 3);
        checkOutput("t3_beat_sent", status_beat_sent, 12);
        checkOutput("t3_done_pulses", dut_done_cnt - done_base, 1);
        repeat (150) tick();
        checkOutput("t3_no_4th_pkt", g_started - start_base, 3);

        // Backpressure held for 100 cycles on the first beat.
        applyStimulus(1, 0, 512, 128, 0);
        waitValid("t4_valid_seen", 20);
        mon_tready = 1'b0;
        repeat (100) tick();
        checkOutput("t4_stall_cycles", status_stall_cycles, 100);
        checkOutput("t4_beat_frozen", status_beat_sent, 0);
        mon_tready = 1'b1;
        applyStimulus(0, 1, 512, 128, 0);
        waitDone("t4_done_seen", 50);
        tick();
        checkOutput("t4_pkt_sent", status_pkt_sent, 1);
        checkOutput("t4_beat_sent", status_beat_sent, 4);
        checkOutput("t4_stall_final", status_stall_cycles, 100);

        // Rejected starts, then a valid start.
        applyStimulus(1, 0, 0, 128, 1);
        checkOutput("t5_err_len0", status_err, 1);
        checkOutput("t5_busy_len0", status_busy, 0);
        checkOutput("t5_enable_len0", gen_enable, 0);
        checkOutput("t5_pkt_untouched", status_pkt_sent, 1);
        applyStimulus(1, 0, 256, 0, 1);
        checkOutput("t5_err_per0", status_err, 1);
        checkOutput("t5_stall_untouched", status_stall_cycles, 100);
        applyStimulus(1, 0, 256, 16, 2);
        checkOutput("t5_err_cleared", status_err, 0);
        checkOutput("t5_busy", status_busy, 1);
        checkOutput("t5_pkt_cleared", status_pkt_sent, 0);
        waitDone("t5_done_seen", 200);
        tick();
        checkOutput("t5_pkt_sent", status_pkt_sent, 2);
        checkOutput("t5_beat_sent", status_beat_sent, 4);

        // Stop during the LOAD cycle goes straight to done.
        done_base = dut_done_cnt;
        applyStimulus(1, 0, 256, 16, 5);
        applyStimulus(0, 1, 256, 16, 5);
        checkOutput("load_stop_done", status_done, 1);
        checkOutput("load_stop_enable", gen_enable, 0);
        tick();
        checkOutput("load_stop_busy", status_busy, 0);
        checkOutput("load_stop_pulses", dut_done_cnt - done_base, 1);
        checkOutput("load_stop_pkt", status_pkt_sent, 0);

        // Reset in the middle of a run, then start and stop in the same cycle.
        applyStimulus(1, 0, 512, 128, 0);
        waitValid("t6_valid_seen", 20);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("t6_rst_enable", gen_enable, 0);
        checkOutput("t6_rst_busy", status_busy, 0);
        checkOutput("t6_rst_beat", status_beat_sent, 0);
        checkOutput("t6_rst_len", gen_pkt_length, 0);
        done_base = dut_done_cnt;
        applyStimulus(1, 1, 512, 128, 0);
        checkOutput("t6_startstop_busy", status_busy, 0);
        repeat (5) tick();
        checkOutput("t6_startstop_idle", status_busy, 0);
        checkOutput("t6_startstop_nodone", dut_done_cnt - done_base, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Overall time limit in case a fault stalls the sequence.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
